// File: rtl/max7219_chain.sv
// max7219_chain: MAX7219 daisy-chain driver. It broadcasts the init sequence, refreshes
// all digits from a frame buffer, and inserts intensity updates between refresh transactions.
module max7219_chain #(
    parameter int         N_DEV      = 1,
    parameter int         CLK_DIV    = 25,
    parameter int         CS_GAP     = 8,
    parameter logic [7:0] SCAN_LIMIT = 8'd7,
    parameter logic [7:0] DECODE     = 8'hFF,
    parameter logic [3:0] INTENSITY  = 4'hF,
    localparam int        DW         = N_DEV > 1 ? $clog2(N_DEV) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_dev,
    input  logic [2:0]    wr_digit,
    input  logic [7:0]    wr_data,
    input  logic          int_set,
    input  logic [3:0]    int_val,
    output logic          spi_clk,
    output logic          dout,
    output logic          cs,
    output logic          init_done,
    output logic          frame_done
);
    localparam int NB  = N_DEV * 16;
    localparam int GAP = CS_GAP * 2 * CLK_DIV;
    localparam int NF  = 2 ** DW;

    typedef enum logic [1:0] {P_GAP, P_SHIFT, P_TAIL} phase_t;
    typedef enum logic [2:0] {S_INIT0, S_INIT1, S_INIT2, S_INIT3, S_INIT4, S_REF, S_INT} seq_t;

    phase_t        phase, phase_nxt;
    seq_t          seq;
    logic [7:0]    fb [NF][8];
    logic [NB-1:0] sr, payload;
    logic [15:0]   bword, dcnt;
    logic [23:0]   gcnt;
    logic [8:0]    bcnt;
    logic [2:0]    digit;
    logic [3:0]    int_reg;
    logic          pending, sclk, tick, start;

    always_comb begin
        bword = seq == S_INIT0 ? 16'h0F00 :
                seq == S_INIT1 ? 16'h0C01 :
                seq == S_INIT2 ? {8'h0B, SCAN_LIMIT} :
                seq == S_INIT3 ? {8'h0A, 4'h0, INTENSITY} :
                seq == S_INIT4 ? {8'h09, DECODE} : {8'h0A, 4'h0, int_reg};
        payload = '0;
        // device 0 sits in the low word so it is shifted out last
        for (int i = 0; i < N_DEV; i++)
            payload[i*16 +: 16] = seq == S_REF ? {8'h01 + {5'd0, digit}, fb[i][digit]} : bword;
    end

    always_comb begin
        tick      = dcnt == 16'(CLK_DIV - 1);
        start     = phase == P_GAP && gcnt == 24'd0;
        phase_nxt = phase == P_GAP   ? (start ? P_SHIFT : P_GAP) :
                    phase == P_SHIFT ? (tick && sclk && bcnt == 9'(NB - 1) ? P_TAIL : P_SHIFT) :
                                       (tick ? P_GAP : P_TAIL);
    end

    assign cs      = phase == P_GAP;
    assign spi_clk = sclk;
    assign dout    = phase == P_SHIFT && sr[NB-1];

    always_ff @(posedge clk) begin
        if (!reset) begin
            phase      <= P_GAP;
            seq        <= S_INIT0;
            gcnt       <= '0;
            dcnt       <= '0;
            bcnt       <= '0;
            sclk       <= 1'b0;
            sr         <= '0;
            digit      <= '0;
            int_reg    <= INTENSITY;
            pending    <= 1'b0;
            init_done  <= 1'b0;
            frame_done <= 1'b0;
            for (int i = 0; i < NF; i++)
                for (int j = 0; j < 8; j++)
                    fb[i][j] <= '0;
        end else begin
            phase      <= phase_nxt;
            frame_done <= 1'b0;
            if (wr_en && 32'(wr_dev) < N_DEV)
                fb[wr_dev][wr_digit] <= wr_data;
            if (int_set) begin
                int_reg <= int_val;
                pending <= 1'b1;
            end else if (start && seq == S_INT)
                pending <= 1'b0;
            if (phase == P_GAP) begin
                if (start) begin
                    sr   <= payload;
                    dcnt <= '0;
                    bcnt <= '0;
                    sclk <= 1'b0;
                end else
                    gcnt <= gcnt - 24'd1;
            end else begin
                dcnt <= tick ? 16'd0 : dcnt + 16'd1;
                if (phase == P_SHIFT && tick) begin
                    sclk <= ~sclk;
                    if (sclk) begin
                        sr   <= sr << 1;
                        bcnt <= bcnt + 9'd1;
                    end
                end
                if (phase == P_TAIL && tick) begin
                    gcnt <= 24'(GAP - 1);
                    if (seq == S_INIT4)
                        init_done <= 1'b1;
                    if (seq == S_REF) begin
                        digit      <= digit + 3'd1;
                        frame_done <= digit == 3'd7;
                    end
                    seq <= seq == S_INIT0 ? S_INIT1 :
                           seq == S_INIT1 ? S_INIT2 :
                           seq == S_INIT2 ? S_INIT3 :
                           seq == S_INIT3 ? S_INIT4 :
                           seq == S_REF && pending ? S_INT : S_REF;
                end
            end
        end
    end
endmodule
